rom_client_cache: RTL
=====================

# rom_client_cache

Per-client ROM read port between a consumer (CPU, tile, sprite or sound fetch logic) and the ROM controller's SDRAM arbiter. It holds one 32-bit cache line, translates narrow client addresses into SDRAM word addresses, and issues held requests on a miss. It serves hits without SDRAM traffic and extracts the 8/16/32-bit client lane from the returned word. One instance per ROM region.

## Interface
- ROM_ADDR_WIDTH, 18: width of client address `rom_addr` (units of ROM_DATA_WIDTH).
- ROM_DATA_WIDTH, 16: client data width; legal values 8, 16, 32.
- ROM_OFFSET, 24'h000000: byte offset of the region in SDRAM; must be a multiple of 4.

- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cs  in  1  client chip select.
- oe  in  1  client output enable; a read is requested only when cs & oe.
- rom_addr  in  ROM_ADDR_WIDTH  client address.
- rom_data  out  ROM_DATA_WIDTH  selected client lane.
- ctrl_addr  out  23  SDRAM 32-bit word address.
- ctrl_req  out  1  request to arbiter, held until ack.
- ctrl_ack  in  1  arbiter accepted request (1-cycle pulse).
- ctrl_valid  in  1  SDRAM read data valid for this client (1-cycle pulse).
- ctrl_data  in  32  SDRAM read data.
- ctrl_hit  out  1  current rom_addr is served from the cache line.

## Operation
- Address math: `ratio` = 32/ROM_DATA_WIDTH (1, 2 or 4). `word` = rom_addr >> log2(ratio). `lane` = rom_addr mod ratio. `ctrl word` = ROM_OFFSET[23:2] + zero-extended `word`, truncated to 23 bits; wrap-around is silent.
- Lane select: lane 0 = ctrl_data bits [W-1:0], lane k = bits [(k+1)W-1:kW] (W = ROM_DATA_WIDTH).
- Cache: registers `line_valid`, `line_tag` (23b ctrl word), `line_data` (32b).
- ctrl_hit = cs & line_valid & (line_tag == ctrl word of rom_addr). This is combinational and independent of FSM state.
- FSM states:
  - IDLE:
    - If cs & oe & !ctrl_hit, latch `req_addr` = ctrl word and go to REQ.
  - REQ:
    - ctrl_req=1, ctrl_addr=req_addr.
    - On ctrl_ack, go to WAIT.
  - WAIT:
    - ctrl_req=0.
    - On ctrl_valid, set line_data=ctrl_data, line_tag=req_addr, line_valid=1, and go to IDLE.
- ctrl_addr = req_addr in REQ/WAIT; otherwise it equals the combinational ctrl word of rom_addr.
- rom_data bypass: if state==WAIT & ctrl_valid & ctrl word of rom_addr == req_addr, rom_data = lane of ctrl_data. Otherwise rom_data = lane of line_data.
- A transaction, once in REQ, always completes. SDRAM requests are never cancelled.
  - If cs drops or rom_addr changes during REQ/WAIT, the fill still completes with req_addr.
  - A new miss is then raised from IDLE.
- A hit on the existing line during REQ/WAIT is served normally.
- ctrl_ack in IDLE/WAIT and ctrl_valid in IDLE/REQ are ignored.

## Timing
- Reset values: state=IDLE, line_valid=0, line_tag=0, line_data=0, req_addr=0, ctrl_req=0, ctrl_hit=0, rom_data=0. ctrl_addr is the combinational ctrl word of rom_addr.
- Miss latency: miss seen in cycle N, ctrl_req high from N+1, held through the ack cycle, low the cycle after.
- Data appears combinationally on rom_data in the ctrl_valid cycle (bypass). It is served from the cache from the next cycle on.
- Hit latency: 0 cycles (combinational ctrl_hit and rom_data).
- Reset mid-transaction: return to IDLE, line invalidated. A stray ctrl_valid after reset is ignored.
- Back-to-back misses: at most one request is outstanding. The next ctrl_req rises no earlier than 1 cycle after ctrl_valid.

## Configuration
- `ROM_CLIENT_CACHE_EN` defined: the cache line is stored as described.
- `ROM_CLIENT_CACHE_EN` undefined:
  - line_valid is held at 0, so ctrl_hit is always 0.
  - Every cs & oe read in IDLE issues a request.
  - rom_data is valid only in the ctrl_valid bypass cycle; otherwise rom_data=0.
  - The client must latch rom_data itself.

## Test plan
- Cold miss, W=16, ROM_OFFSET=24'h040000, rom_addr=5 → ctrl_req rises next cycle with ctrl_addr=23'h010002. Ack it; then ctrl_valid with ctrl_data=32'hDEADBEEF → rom_data=16'hDEAD in the valid cycle, line_valid=1.
- Follow-up rom_addr=4 → ctrl_hit=1 the same cycle, rom_data=16'hBEEF, no ctrl_req.
- W=8, rom_addr=3 with ctrl_data=32'h11223344 → rom_data=8'h11. Then rom_addr=0 → hit, rom_data=8'h44.
- Ack delayed 7 cycles → ctrl_req and ctrl_addr stable for all 7 cycles. rom_addr changed to a different word during WAIT → line filled with the old req_addr, no bypass, then a new ctrl_req.
- Reset asserted in WAIT, then ctrl_valid pulsed → state IDLE, line_valid=0, ctrl_hit=0, rom_data=0.
- Build without ROM_CLIENT_CACHE_EN: two reads of the same address → two separate ctrl_req/ctrl_ack sequences, ctrl_hit never 1.

Source files
------------

// File: rtl/rom_client_cache.sv
// rom_client_cache: per-client ROM read port with a one-line cache in front of the SDRAM arbiter.
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   cs, oe       client select / output enable; a read is requested on cs & oe
//   rom_addr     client address in ROM_DATA_WIDTH units
//   rom_data     selected client lane (bypassed from ctrl_data in the fill cycle)
//   ctrl_addr    SDRAM 32-bit word address (held request address while busy)
//   ctrl_req     request to arbiter, held until ctrl_ack
//   ctrl_ack     arbiter accepted the request
//   ctrl_valid   read data valid for this client
//   ctrl_data    SDRAM read data
//   ctrl_hit     current rom_addr is served from the cache line
//
// Build option ROM_CLIENT_CACHE_EN: when defined the fetched line is kept and
// served as hits; when undefined every read fetches and rom_data is only
// valid in the ctrl_valid cycle.
module rom_client_cache #(
  parameter int          ROM_ADDR_WIDTH = 18,
  parameter int          ROM_DATA_WIDTH = 16,
  parameter logic [23:0] ROM_OFFSET     = 24'h000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs,
  input  logic                      oe,
  input  logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic [ROM_DATA_WIDTH-1:0] rom_data,
  output logic [22:0]               ctrl_addr,
  output logic                      ctrl_req,
  input  logic                      ctrl_ack,
  input  logic                      ctrl_valid,
  input  logic [31:0]               ctrl_data,
  output logic                      ctrl_hit
);
  localparam int RATIO = 32 / ROM_DATA_WIDTH;
  localparam int LSB = $clog2(RATIO);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t      r_state, w_next;
  logic [22:0] r_req_addr, w_word, w_line_tag;
  logic [31:0] w_line_data;
  logic [1:0]  w_lane;
  logic        w_line_valid, w_miss, w_fill, w_bypass;
  // Region offset is word aligned, so only its word part is added; overflow wraps.
  assign w_word = 23'(rom_addr >> LSB) + 23'(ROM_OFFSET[23:2]);
  assign w_lane = 2'(rom_addr % RATIO);
  assign ctrl_hit = cs && w_line_valid && (w_line_tag == w_word);
  assign w_miss = (r_state == S_IDLE) && cs && oe && !ctrl_hit;
  assign w_fill = (r_state == S_WAIT) && ctrl_valid;
  // Only forward the returning word if the client is still asking for it.
  assign w_bypass = w_fill && (w_word == r_req_addr);
  assign rom_data = ROM_DATA_WIDTH'((w_bypass ? ctrl_data : w_line_data) >> (w_lane * ROM_DATA_WIDTH));
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    ctrl_req = 1'b0;
    ctrl_addr = w_word;
    case (r_state)
      S_IDLE: w_next = w_miss ? S_REQ : S_IDLE;
      S_REQ: begin
        ctrl_req = 1'b1;
        ctrl_addr = r_req_addr;
        w_next = ctrl_ack ? S_WAIT : S_REQ;
      end
      S_WAIT: begin
        ctrl_addr = r_req_addr;
        w_next = ctrl_valid ? S_IDLE : S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_req_addr <= '0;
    else if (w_miss) r_req_addr <= w_word;
`ifdef ROM_CLIENT_CACHE_EN
  logic        r_line_valid;
  logic [22:0] r_line_tag;
  logic [31:0] r_line_data;
  // The line is always filled with the requested word, even if the client moved on.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_line_valid <= 1'b0;
      r_line_tag <= '0;
      r_line_data <= '0;
    end else if (w_fill) begin
      r_line_valid <= 1'b1;
      r_line_tag <= r_req_addr;
      r_line_data <= ctrl_data;
    end
  assign w_line_valid = r_line_valid;
  assign w_line_tag = r_line_tag;
  assign w_line_data = r_line_data;
`else
  assign w_line_valid = 1'b0;
  assign w_line_tag = '0;
  assign w_line_data = '0;
`endif
endmodule
